// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: channel state encoding
// and the limits used to validate parameters at elaboration.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MIN_COUNT       = 2;

    // A terminal count must be at least MIN_COUNT and representable in cnt_w bits.
    function automatic bit count_fits(input longint count, input int cnt_w);
        return (count >= longint'(MIN_COUNT)) && (count < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: pin synchroniser, debounce/repeat FSM with a shared
// counter, and registered level/strobe outputs.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int CNT_W        = 24,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_COUNT     = 1000000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_COUNT = 16000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic press_nxt_o,
    output logic release_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pin_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    // The one counter serves both the debounce window and the repeat interval.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (REPEAT_EN != 0) begin
                    if (cnt_q == RPT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // Bounce back high restarts the repeat interval from zero.
                if (s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign press_nxt_o = press_d;
    assign release_o   = release_q;
    assign repeat_o    = repeat_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: one debounce_chan per input plus a registered
// OR of the press strobes, with elaboration-time parameter checks.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 24,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_COUNT     = 1000000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_COUNT = 16000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] i_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o,
    output logic                any_press_o
);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be at least 2");
    end
    if (!count_fits(longint'(DB_COUNT), CNT_W)) begin : g_bad_db
        $error("debounce_multi: DB_COUNT out of range for CNT_W");
    end
    if (!count_fits(longint'(REPEAT_COUNT), CNT_W)) begin : g_bad_rpt
        $error("debounce_multi: REPEAT_COUNT out of range for CNT_W");
    end

    logic [CHANNELS-1:0] press_nxt;
    logic                any_press_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        debounce_chan #(
            .CNT_W        (CNT_W),
            .SYNC_STAGES  (SYNC_STAGES),
            .DB_COUNT     (DB_COUNT),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_COUNT (REPEAT_COUNT)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .pin_i       (i_i[ch]),
            .level_o     (level_o[ch]),
            .press_o     (press_o[ch]),
            .press_nxt_o (press_nxt[ch]),
            .release_o   (release_o[ch]),
            .repeat_o    (repeat_o[ch])
        );
    end

    // Registered from the channels' next-state press so it lines up with press_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_nxt;
        end
    end

    assign any_press_o = any_press_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: run-length reference model compared every cycle,
// plus directed scenarios with hand-computed event times.
module tb_debounce_multi;

    localparam int CH  = 2;
    localparam int CW  = 8;
    localparam int SYN = 2;
    localparam int DB  = 10;
    localparam int RC  = 20;
    localparam int REN = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] i_i = '0;
    logic [CH-1:0] level_o, press_o, release_o, repeat_o;
    logic          any_press_o;

    debounce_multi #(
        .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SYN),
        .DB_COUNT(DB), .REPEAT_EN(REN), .REPEAT_COUNT(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_i(i_i),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .repeat_o(repeat_o), .any_press_o(any_press_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the pin is seen SYN edges late; the level flips after DB
    // consecutive samples disagreeing with it; while held, a repeat fires every
    // RC samples counted from the press, the last repeat, or the end of a glitch.
    logic [SYN-1:0][CH-1:0] m_pipe;
    int                     m_run [CH];
    int                     m_hold[CH];
    logic [CH-1:0]          m_level, m_press, m_rel, m_rep;
    logic                   m_any;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe  <= '0;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_rep   <= '0;
            m_any   <= 1'b0;
            for (int ch = 0; ch < CH; ch++) begin
                m_run[ch]  <= 0;
                m_hold[ch] <= 0;
            end
        end else begin
            logic [CH-1:0] pr, rl, rp, lv;
            pr = '0; rl = '0; rp = '0; lv = m_level;
            for (int ch = 0; ch < CH; ch++) begin
                automatic int   run  = m_run[ch];
                automatic int   hold = m_hold[ch];
                automatic logic s    = m_pipe[SYN-1][ch];
                if (!lv[ch]) begin
                    run = s ? run + 1 : 0;
                    if (run == DB) begin
                        lv[ch] = 1'b1; pr[ch] = 1'b1; run = 0; hold = 0;
                    end
                end else if (!s) begin
                    run = run + 1;
                    if (run == DB) begin
                        lv[ch] = 1'b0; rl[ch] = 1'b1; run = 0; hold = 0;
                    end
                end else if (run > 0) begin
                    run = 0; hold = 0;
                end else if (REN != 0) begin
                    hold = hold + 1;
                    if (hold == RC) begin
                        rp[ch] = 1'b1; hold = 0;
                    end
                end
                m_run[ch]  <= run;
                m_hold[ch] <= hold;
            end
            m_level <= lv;
            m_press <= pr;
            m_rel   <= rl;
            m_rep   <= rp;
            m_any   <= |pr;
            m_pipe  <= {m_pipe[SYN-2:0], i_i};
        end
    end

    always @(negedge clk) begin
        chk("level",     int'(level_o),     int'(m_level));
        chk("press",     int'(press_o),     int'(m_press));
        chk("release",   int'(release_o),   int'(m_rel));
        chk("repeat",    int'(repeat_o),    int'(m_rep));
        chk("any_press", int'(any_press_o), int'(m_any));
    end

    int pr0_q[$], pr1_q[$], rl0_q[$], rp0_q[$], any_q[$];

    always @(negedge clk) begin
        if (press_o[0])   pr0_q.push_back(cyc);
        if (press_o[1])   pr1_q.push_back(cyc);
        if (release_o[0]) rl0_q.push_back(cyc);
        if (repeat_o[0])  rp0_q.push_back(cyc);
        if (any_press_o)  any_q.push_back(cyc);
    end

    task automatic clr_q();
        pr0_q.delete(); pr1_q.delete(); rl0_q.delete(); rp0_q.delete(); any_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks event count, then the offsets of the first one or two events from base.
    task automatic chk_ev(input string name, input int q[$], input int base,
                          input int n, input int o0, input int o1);
        chk({name, "_count"}, q.size(), n);
        if (n > 0) chk({name, "_t0"}, (q.size() > 0) ? q[0] - base : -1, o0);
        if (n > 1) chk({name, "_t1"}, (q.size() > 1) ? q[1] - base : -1, o1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_level"}, int'(level_o), 0);
        chk({name, "_strobes"}, int'({press_o, release_o, repeat_o, any_press_o}), 0);
    endtask

    int r, g, rr;

    initial begin
        wait_cyc(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_cyc(3);

        // Clean press, held 15 cycles
        clr_q(); r = cyc;
        i_i[0] = 1'b1;
        wait_cyc(12);
        chk("clean_level_at_press", int'(level_o[0]), 1);
        wait_cyc(3);
        i_i[0] = 1'b0;
        wait_cyc(20);
        chk_ev("clean_press", pr0_q, r, 1, 12, 0);
        chk_ev("clean_repeat", rp0_q, r, 0, 0, 0);
        chk_ev("clean_release", rl0_q, r, 1, 27, 0);

        // Bounce: 9 high / 3 low, five times
        clr_q();
        for (int k = 0; k < 5; k++) begin
            i_i[0] = 1'b1; wait_cyc(9);
            i_i[0] = 1'b0; wait_cyc(3);
        end
        wait_cyc(15);
        chk_ev("bounce_press", pr0_q, 0, 0, 0, 0);
        chk_ev("bounce_release", rl0_q, 0, 0, 0, 0);
        chk("bounce_level", int'(level_o[0]), 0);

        // Long hold with auto-repeat, then release
        clr_q(); r = cyc;
        i_i[0] = 1'b1; wait_cyc(60);
        i_i[0] = 1'b0; wait_cyc(20);
        chk_ev("hold_press", pr0_q, r, 1, 12, 0);
        chk_ev("hold_repeat", rp0_q, r, 2, 32, 52);
        chk_ev("hold_release", rl0_q, r, 1, 72, 0);

        // 5-cycle low glitch while held; repeat restarts once the FSM sees the
        // pin high again, SYN+1 edges after it is driven high.
        clr_q(); r = cyc;
        i_i[0] = 1'b1; wait_cyc(25);
        i_i[0] = 1'b0; wait_cyc(5);
        g = cyc;
        i_i[0] = 1'b1; wait_cyc(30);
        i_i[0] = 1'b0; wait_cyc(20);
        chk_ev("glitch_press", pr0_q, r, 1, 12, 0);
        chk_ev("glitch_repeat", rp0_q, g, 1, SYN + 1 + RC, 0);
        chk_ev("glitch_release", rl0_q, r, 1, 72, 0);

        // Reset during PRESS_WAIT with the pin held
        clr_q();
        i_i[0] = 1'b1; wait_cyc(6);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_pw");
        wait_cyc(3);
        chk_ev("rst_pw_no_press", pr0_q, 0, 0, 0, 0);
        rst_n = 1'b1; rr = cyc;
        wait_cyc(16);
        chk_ev("rst_pw_press", pr0_q, rr, 1, 12, 0);

        // Reset during HELD with the pin held
        clr_q();
        chk("held_level_before_rst", int'(level_o[0]), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_held");
        wait_cyc(2);
        rst_n = 1'b1; rr = cyc;
        wait_cyc(16);
        chk_ev("rst_held_press", pr0_q, rr, 1, 12, 0);
        chk_ev("rst_held_release", rl0_q, 0, 0, 0, 0);
        i_i[0] = 1'b0; wait_cyc(20);

        // Both channels together
        clr_q(); r = cyc;
        i_i = 2'b11; wait_cyc(16);
        i_i = 2'b00; wait_cyc(20);
        chk_ev("both_press0", pr0_q, r, 1, 12, 0);
        chk_ev("both_press1", pr1_q, r, 1, 12, 0);
        chk_ev("both_any", any_q, r, 1, 12, 0);

        // Channels offset by 3 cycles
        clr_q(); r = cyc;
        i_i[0] = 1'b1; wait_cyc(3);
        i_i[1] = 1'b1; wait_cyc(16);
        i_i = 2'b00; wait_cyc(20);
        chk_ev("offset_press1", pr1_q, r, 1, 15, 0);
        chk_ev("offset_any", any_q, r, 2, 12, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
